tl_mem_manager: RTL and testbench

//  Non-coherent TileLink manager backed by a flop memory; sits directly downstream of the client side of tilelink_if.

---
 rtl/tl_mem_manager.sv | 196 +++++++++++++++++++
 tb/tb_tl_mem_manager.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_mem_manager.sv
// tl_mem_manager: non-coherent TileLink manager over a flop memory.
// Serves built-in Get/GetBlock/Put/PutBlock, returns one grant (or a
// block of grant beats), then holds the transaction open until the
// matching Finish arrives. Only one transaction is in flight at a time.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   S_IDLE    | ready for a new acquire
//   S_PUT     | collecting beats 1..7 of a PutBlock
//   S_GRANT   | presenting a single grant beat (ack or Get data)
//   S_GBLK    | presenting GetBlock data beats 0..7
//   S_WFIN    | waiting for the finish carrying the current mxid
module tl_mem_manager #(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = 10
) (
  input  logic        clk,
  input  logic        reset,
  output logic        acquire_ready,
  input  logic        acquire_valid,
  input  logic [25:0] acquire_bits_addr_block,
  input  logic [1:0]  acquire_bits_client_xact_id,
  input  logic [2:0]  acquire_bits_addr_beat,
  input  logic        acquire_bits_is_builtin_type,
  input  logic [2:0]  acquire_bits_a_type,
  input  logic [11:0] acquire_bits_union,
  input  logic [63:0] acquire_bits_data,
  input  logic        acquire_bits_client_id,
  input  logic        grant_ready,
  output logic        grant_valid,
  output logic [2:0]  grant_bits_addr_beat,
  output logic [1:0]  grant_bits_client_xact_id,
  output logic [3:0]  grant_bits_manager_xact_id,
  output logic        grant_bits_is_builtin_type,
  output logic [3:0]  grant_bits_g_type,
  output logic [63:0] grant_bits_data,
  output logic        grant_bits_client_id,
  output logic        finish_ready,
  input  logic        finish_valid,
  input  logic [3:0]  finish_bits_manager_xact_id,
  output logic        err_finish
);

  localparam int BLK_W = IDX_W - 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PUT   = 3'd1;
  localparam logic [2:0] S_GRANT = 3'd2;
  localparam logic [2:0] S_GBLK  = 3'd3;
  localparam logic [2:0] S_WFIN  = 3'd4;

  localparam logic [3:0] G_PREFETCH_ACK = 4'd1;
  localparam logic [3:0] G_PUT_ACK      = 4'd3;
  localparam logic [3:0] G_DATA_BEAT    = 4'd4;
  localparam logic [3:0] G_DATA_BLOCK   = 4'd5;

  logic [2:0]       state;
  logic [2:0]       cnt;
  logic [BLK_W-1:0] blk;
  logic [1:0]       xid;
  logic             cid;
  logic [3:0]       gtype;
  logic [3:0]       mxid;

  logic [63:0]      mem [MEM_WORDS];

  logic             acq_fire;
  logic             is_builtin_op;
  logic             we;
  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] ridx;
  logic [7:0]       wmask;

  // Block address bits above the memory index and the unused union bits
  // have no effect on this manager (index is taken modulo MEM_WORDS).
  logic unused_acq;
  assign unused_acq = ^{acquire_bits_addr_block[25:BLK_W],
                        acquire_bits_union[11:9], acquire_bits_union[0]};

  assign acquire_ready = (state == S_IDLE) || (state == S_PUT);
  assign acq_fire      = acquire_valid && acquire_ready;
  assign is_builtin_op = acquire_bits_is_builtin_type && (acquire_bits_a_type <= 3'd3);
  assign wmask         = acquire_bits_union[8:1];

  assign grant_valid                = (state == S_GRANT) || (state == S_GBLK);
  assign finish_ready               = (state == S_WFIN);
  assign grant_bits_addr_beat       = cnt;
  assign grant_bits_client_xact_id  = xid;
  assign grant_bits_client_id       = cid;
  assign grant_bits_manager_xact_id = mxid;
  assign grant_bits_is_builtin_type = 1'b1;
  assign grant_bits_g_type          = gtype;

  // Read data comes straight from the array; acks carry zero data.
  assign ridx            = {blk, cnt};
  assign grant_bits_data = ((gtype == G_DATA_BEAT) || (gtype == G_DATA_BLOCK)) ? mem[ridx] : 64'd0;

  // Write-port decode: first beat of Put/PutBlock uses the acquire address,
  // later PutBlock beats use the latched block and internal beat count.
  always_comb begin
    we   = 1'b0;
    widx = {acquire_bits_addr_block[BLK_W-1:0], acquire_bits_addr_beat};
    if (acq_fire && !reset) begin
      if (state == S_IDLE) begin
        we = is_builtin_op && acquire_bits_a_type[1];
      end else begin
        we   = 1'b1;
        widx = {blk, cnt};
      end
    end
  end

  // Byte-masked storage write; contents are not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we && wmask[i]) mem[widx][8*i +: 8] <= acquire_bits_data[8*i +: 8];
    end
  end

  // Transaction sequencing, beat counting and finish-id tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      blk        <= '0;
      xid        <= 2'd0;
      cid        <= 1'b0;
      gtype      <= 4'd0;
      mxid       <= 4'd0;
      err_finish <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (acq_fire) begin
            xid <= acquire_bits_client_xact_id;
            cid <= acquire_bits_client_id;
            blk <= acquire_bits_addr_block[BLK_W-1:0];
            cnt <= acquire_bits_addr_beat;
            if (!is_builtin_op) begin
              gtype <= G_PREFETCH_ACK;
              state <= S_GRANT;
            end else begin
              case (acquire_bits_a_type)
                3'd0: begin
                  gtype <= G_DATA_BEAT;
                  state <= S_GRANT;
                end
                3'd1: begin
                  gtype <= G_DATA_BLOCK;
                  cnt   <= 3'd0;
                  state <= S_GBLK;
                end
                3'd2: begin
                  gtype <= G_PUT_ACK;
                  state <= S_GRANT;
                end
                default: begin
                  gtype <= G_PUT_ACK;
                  cnt   <= 3'd1;
                  state <= S_PUT;
                end
              endcase
            end
          end
        end
        S_PUT: begin
          if (acq_fire) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (grant_ready) state <= S_WFIN;
        end
        S_GBLK: begin
          if (grant_ready) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) state <= S_WFIN;
          end
        end
        S_WFIN: begin
          if (finish_valid) begin
            if (finish_bits_manager_xact_id == mxid) begin
              mxid  <= mxid + 4'd1;
              state <= S_IDLE;
            end else begin
              err_finish <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_mem_manager.sv
// Scoreboard bench for tl_mem_manager: stimulus pushes expected grant beats
// computed from a reference memory array; a monitor pops and compares on
// every grant handshake and checks that stalled grants hold steady.
module tb_tl_mem_manager;

  logic        clk = 1'b0;
  logic        reset;
  logic        acquire_ready;
  logic        acquire_valid;
  logic [25:0] acquire_bits_addr_block;
  logic [1:0]  acquire_bits_client_xact_id;
  logic [2:0]  acquire_bits_addr_beat;
  logic        acquire_bits_is_builtin_type;
  logic [2:0]  acquire_bits_a_type;
  logic [11:0] acquire_bits_union;
  logic [63:0] acquire_bits_data;
  logic        acquire_bits_client_id;
  logic        grant_ready;
  logic        grant_valid;
  logic [2:0]  grant_bits_addr_beat;
  logic [1:0]  grant_bits_client_xact_id;
  logic [3:0]  grant_bits_manager_xact_id;
  logic        grant_bits_is_builtin_type;
  logic [3:0]  grant_bits_g_type;
  logic [63:0] grant_bits_data;
  logic        grant_bits_client_id;
  logic        finish_ready;
  logic        finish_valid;
  logic [3:0]  finish_bits_manager_xact_id;
  logic        err_finish;

  tl_mem_manager dut (
    .clk(clk), .reset(reset),
    .acquire_ready(acquire_ready), .acquire_valid(acquire_valid),
    .acquire_bits_addr_block(acquire_bits_addr_block),
    .acquire_bits_client_xact_id(acquire_bits_client_xact_id),
    .acquire_bits_addr_beat(acquire_bits_addr_beat),
    .acquire_bits_is_builtin_type(acquire_bits_is_builtin_type),
    .acquire_bits_a_type(acquire_bits_a_type),
    .acquire_bits_union(acquire_bits_union),
    .acquire_bits_data(acquire_bits_data),
    .acquire_bits_client_id(acquire_bits_client_id),
    .grant_ready(grant_ready), .grant_valid(grant_valid),
    .grant_bits_addr_beat(grant_bits_addr_beat),
    .grant_bits_client_xact_id(grant_bits_client_xact_id),
    .grant_bits_manager_xact_id(grant_bits_manager_xact_id),
    .grant_bits_is_builtin_type(grant_bits_is_builtin_type),
    .grant_bits_g_type(grant_bits_g_type),
    .grant_bits_data(grant_bits_data),
    .grant_bits_client_id(grant_bits_client_id),
    .finish_ready(finish_ready), .finish_valid(finish_valid),
    .finish_bits_manager_xact_id(finish_bits_manager_xact_id),
    .err_finish(err_finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  gt;
    logic [2:0]  beat;
    bit          chk_beat;
    logic [63:0] data;
    logic [1:0]  xid;
    logic        cid;
    logic [3:0]  mx;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] ref_mem [1024];
  logic [63:0] pb_data [8];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_mxid = 4'd0;
  logic        exp_err = 1'b0;
  logic [1:0]  cur_xid = 2'd0;
  logic        cur_cid = 1'b0;
  bit          stall_en = 1'b0;
  int          stall_left = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [25:0] blk, input logic [2:0] beat);
    return (int'(blk) * 8 + int'(beat)) % 1024;
  endfunction

  task automatic model_write(input int idx, input logic [7:0] mask, input logic [63:0] d);
    for (int i = 0; i < 8; i++) if (mask[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic push_exp(input logic [3:0] gt, input logic [2:0] beat, input bit cb, input logic [63:0] d);
    exp_t e;
    e.gt = gt; e.beat = beat; e.chk_beat = cb; e.data = d;
    e.xid = cur_xid; e.cid = cur_cid; e.mx = exp_mxid;
    sbq.push_back(e);
  endtask

  // Grant-ready driver: random backpressure, plus a directed 5-cycle stall
  // on beat 2 of a GetBlock when stall_en is set.
  initial begin
    grant_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_en && grant_valid && grant_bits_g_type == 4'd5 &&
          grant_bits_addr_beat == 3'd2 && stall_left > 0) begin
        grant_ready = 1'b0;
        stall_left--;
      end else begin
        grant_ready = ($urandom_range(3) != 0);
      end
    end
  end

  // Monitor: compare on each grant handshake; check stalled beats hold.
  logic        stalled_prev = 1'b0;
  logic [2:0]  h_beat;
  logic [63:0] h_data;
  logic [3:0]  h_gt;
  always @(negedge clk) begin
    if (!reset && grant_valid) begin
      if (stalled_prev) begin
        chk("hold_beat", grant_bits_addr_beat, h_beat);
        chk("hold_data", grant_bits_data, h_data);
        chk("hold_gtype", grant_bits_g_type, h_gt);
      end
      if (grant_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_grant", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("g_type", grant_bits_g_type, e.gt);
          chk("data", grant_bits_data, e.data);
          chk("client_xact_id", grant_bits_client_xact_id, e.xid);
          chk("client_id", grant_bits_client_id, e.cid);
          chk("manager_xact_id", grant_bits_manager_xact_id, e.mx);
          chk("is_builtin", grant_bits_is_builtin_type, 1'b1);
          if (e.chk_beat) chk("addr_beat", grant_bits_addr_beat, e.beat);
        end
      end
      stalled_prev = !grant_ready;
      h_beat = grant_bits_addr_beat;
      h_data = grant_bits_data;
      h_gt   = grant_bits_g_type;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  // One acquire beat; called just after a rising edge, returns #1 after
  // the edge on which the handshake happened.
  task automatic acq(input logic [25:0] blk, input logic [2:0] beat, input logic bi,
                     input logic [2:0] at, input logic [7:0] mask, input logic [63:0] d);
    int n = 0;
    acquire_valid                = 1'b1;
    acquire_bits_addr_block      = blk;
    acquire_bits_addr_beat       = beat;
    acquire_bits_is_builtin_type = bi;
    acquire_bits_a_type          = at;
    acquire_bits_union           = {3'($urandom), mask, 1'($urandom)};
    acquire_bits_data            = d;
    acquire_bits_client_xact_id  = cur_xid;
    acquire_bits_client_id       = cur_cid;
    @(negedge clk);
    while (!acquire_ready && n < 50) begin n++; @(negedge clk); end
    if (!acquire_ready) chk("acquire_ready_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    acquire_valid = 1'b0;
  endtask

  task automatic fin(input logic [3:0] id);
    int n = 0;
    finish_valid = 1'b1;
    finish_bits_manager_xact_id = id;
    @(negedge clk);
    while (!finish_ready && n < 50) begin n++; @(negedge clk); end
    if (!finish_ready) chk("finish_ready_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    finish_valid = 1'b0;
    if (id == exp_mxid) exp_mxid = exp_mxid + 4'd1;
    else exp_err = 1'b1;
  endtask

  task automatic wait_grants();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin n++; @(posedge clk); end
    if (sbq.size() != 0) begin
      chk("grant_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  // kind: 0 Get, 1 GetBlock, 2 Put, 3 PutBlock (pb_data), 4 non-builtin/unknown.
  task automatic xact(input int kind, input logic [25:0] blk, input logic [2:0] beat,
                      input logic [7:0] mask, input logic [63:0] d, input bit bad_fin);
    cur_xid = 2'($urandom);
    cur_cid = 1'($urandom);
    case (kind)
      0: begin
        push_exp(4'd4, beat, 1'b1, ref_mem[idx_of(blk, beat)]);
        acq(blk, beat, 1'b1, 3'd0, mask, d);
      end
      1: begin
        for (int i = 0; i < 8; i++) push_exp(4'd5, 3'(i), 1'b1, ref_mem[idx_of(blk, 3'(i))]);
        acq(blk, beat, 1'b1, 3'd1, mask, d);
      end
      2: begin
        push_exp(4'd3, 3'd0, 1'b0, 64'd0);
        acq(blk, beat, 1'b1, 3'd2, mask, d);
        model_write(idx_of(blk, beat), mask, d);
      end
      3: begin
        push_exp(4'd3, 3'd0, 1'b0, 64'd0);
        for (int i = 0; i < 8; i++) begin
          acq(blk, (i == 0) ? 3'd0 : 3'($urandom), 1'b1, 3'd3, mask, pb_data[i]);
          model_write(idx_of(blk, 3'(i)), mask, pb_data[i]);
        end
      end
      default: begin
        push_exp(4'd1, 3'd0, 1'b0, 64'd0);
        if ($urandom_range(1) == 0) acq(blk, beat, 1'b0, 3'($urandom), mask, d);
        else acq(blk, beat, 1'b1, 3'($urandom_range(7, 4)), mask, d);
      end
    endcase
    chk("grant_latency", grant_valid, 1'b1);
    wait_grants();
    if (bad_fin) begin
      fin(exp_mxid + 4'd2);
      chk("err_finish_set", err_finish, 1'b1);
      chk("still_wait_fin", finish_ready, 1'b1);
    end
    fin(exp_mxid);
    chk("back_to_idle", acquire_ready, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_mxid = 4'd0;
    exp_err  = 1'b0;
  endtask

  logic [25:0] rblk;
  logic [63:0] d64;

  initial begin
    reset = 1'b1;
    acquire_valid = 1'b0;
    acquire_bits_addr_block = '0; acquire_bits_addr_beat = '0;
    acquire_bits_is_builtin_type = 1'b0; acquire_bits_a_type = '0;
    acquire_bits_union = '0; acquire_bits_data = '0;
    acquire_bits_client_xact_id = '0; acquire_bits_client_id = 1'b0;
    finish_valid = 1'b0; finish_bits_manager_xact_id = '0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    chk("rst_acquire_ready", acquire_ready, 1'b1);
    chk("rst_grant_valid", grant_valid, 1'b0);
    chk("rst_finish_ready", finish_ready, 1'b0);
    chk("rst_err_finish", err_finish, 1'b0);
    @(posedge clk); #1;

    // Put idx 5 full mask, bad finish id 2 then correct id 0; Get idx 5.
    xact(2, 26'd0, 3'd5, 8'hFF, 64'h1122334455667788, 1'b1);
    chk("err_finish_sticky", err_finish, exp_err);
    xact(0, 26'd0, 3'd5, 8'h00, 64'd0, 1'b0);

    // Partial mask write over zero.
    xact(2, 26'd1, 3'd1, 8'hFF, 64'd0, 1'b0);
    xact(2, 26'd1, 3'd1, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk("model_partial", ref_mem[9], 64'h0000_0000_FFFF_FFFF);
    xact(0, 26'd1, 3'd1, 8'h00, 64'd0, 1'b0);

    // Fill the whole memory with PutBlocks (upper block bits exercise the modulo).
    for (int b = 0; b < 128; b++) begin
      for (int i = 0; i < 8; i++) pb_data[i] = {$urandom, $urandom};
      xact(3, {19'($urandom), 7'(b)}, 3'd0, 8'hFF, 64'd0, 1'b0);
    end

    // PutBlock block 3 then GetBlock block 3 with a stall on beat 2.
    for (int i = 0; i < 8; i++) pb_data[i] = 64'hD0D0_0000_0000_0000 + 64'(i);
    xact(3, 26'd3, 3'd0, 8'hFF, 64'd0, 1'b0);
    stall_en = 1'b1; stall_left = 5;
    xact(1, 26'd3, 3'd0, 8'h00, 64'd0, 1'b0);
    chk("stall_applied", 64'(stall_left), 64'd0);
    stall_en = 1'b0;

    // Non-builtin / unknown types must not touch memory.
    xact(4, 26'd2, 3'd4, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    xact(0, 26'd2, 3'd4, 8'h00, 64'd0, 1'b0);

    // Random mix.
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < 8; i++) pb_data[i] = {$urandom, $urandom};
      d64 = {$urandom, $urandom};
      xact(int'($urandom_range(4)), 26'($urandom), 3'($urandom), 8'($urandom), d64, 1'b0);
    end
    chk("err_finish_final", err_finish, exp_err);

    // Reset in the middle of a PutBlock after beat 3.
    rblk = 26'd77;
    cur_xid = 2'd1; cur_cid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d64 = 64'hABCD_0000_0000_0000 + 64'(i);
      acq(rblk, 3'(i), 1'b1, 3'd3, 8'hFF, d64);
      model_write(idx_of(rblk, 3'(i)), 8'hFF, d64);
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_grant_after_reset", grant_valid, 1'b0);
    end
    chk("idle_after_reset", acquire_ready, 1'b1);
    chk("err_cleared", err_finish, 1'b0);
    @(posedge clk); #1;
    xact(1, rblk, 3'd0, 8'h00, 64'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
